// File: rtl/addsub_seq32_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package addsub_seq32_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Byte-index counter width: clog2(bytes), never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned bytes);
      return (bytes <= 1) ? 1 : $clog2(bytes);
   endfunction

endpackage

// File: rtl/addsub_seq32_addsub8.sv
// Combinational 8-bit add/subtract slice with carry in and carry out.
module addsub8
   import addsub_seq32_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              sub_i,
   input  logic              cin_i,
   output logic [BYTE_W-1:0] s_o,
   output logic              cout_o
);

   logic [BYTE_W-1:0] be;

   // a + (sub ? ~b : b) + cin; the +1 of subtraction arrives through cin.
   always_comb begin
      be            = sub_i ? ~b_i : b_i;
      {cout_o, s_o} = {1'b0, a_i} + {1'b0, be} + {{BYTE_W{1'b0}}, cin_i};
   end

endmodule

// File: rtl/addsub_seq32.sv
// Byte-serial multi-byte add/subtract sequencer driving one addsub8 slice,
// LSB byte first, with result and compare flags loaded on completion.
module addsub_seq32
   import addsub_seq32_pkg::*;
#(
   parameter  int unsigned BYTES = 4,
   localparam int unsigned W     = BYTE_W * BYTES
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic         cout,
   output logic         zero,
   output logic         ovf,
   output logic         lt,
   output logic         ltu
);

   localparam int unsigned   IW       = idx_width(BYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

   state_e state_q, state_d;

   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  res_q, res_d;
   logic          sub_q, sub_d;
   logic          carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [W-1:0]  q_q, q_d;
   logic          cout_q, cout_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;
   logic          lt_q, lt_d;
   logic          ltu_q, ltu_d;

   logic [BYTE_W-1:0] s8;
   logic              c8;
   logic [W-1:0]      q_fin;
   logic              be_msb;
   logic              ovf_fin;
   logic              accept;
   logic              last_byte;

   addsub8 u_addsub8 (
      .a_i    (a_sh_q[BYTE_W-1:0]),
      .b_i    (b_sh_q[BYTE_W-1:0]),
      .sub_i  (sub_q),
      .cin_i  (carry_q),
      .s_o    (s8),
      .cout_o (c8)
   );

   assign accept    = start && (state_q != ST_RUN);
   assign last_byte = (state_q == ST_RUN) && (idx_q == LAST_IDX);

   // Next-state logic: DONE accepts a new start directly (back-to-back).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_byte) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: load on accept, shift one byte per RUN cycle,
   // publish result and flags together on the final byte.
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      q_d     = q_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      lt_d    = lt_q;
      ltu_d   = ltu_q;

      // New byte enters the result from the top; on the last byte this is
      // the complete W-bit result.
      q_fin   = W'({s8, res_q} >> BYTE_W);
      // On the last byte the low lanes of the shift registers hold the
      // operand MSB bytes, so operand sign bits are read from there.
      be_msb  = sub_q ^ b_sh_q[BYTE_W-1];
      ovf_fin = (a_sh_q[BYTE_W-1] == be_msb) && (s8[BYTE_W-1] != a_sh_q[BYTE_W-1]);

      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = b;
         sub_d   = sub;
         carry_d = sub;
         idx_d   = '0;
      end else if (state_q == ST_RUN) begin
         a_sh_d  = a_sh_q >> BYTE_W;
         b_sh_d  = b_sh_q >> BYTE_W;
         res_d   = q_fin;
         carry_d = c8;
         idx_d   = idx_q + IW'(1);
         if (idx_q == LAST_IDX) begin
            q_d    = q_fin;
            cout_d = c8;
            zero_d = (q_fin == '0);
            ovf_d  = ovf_fin;
            lt_d   = sub_q & (s8[BYTE_W-1] ^ ovf_fin);
            ltu_d  = sub_q & ~c8;
         end
      end
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         q_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         lt_q    <= 1'b0;
         ltu_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         q_q     <= q_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         lt_q    <= lt_d;
         ltu_q   <= ltu_d;
      end
   end

   assign ready = (state_q != ST_RUN);
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign q     = q_q;
   assign cout  = cout_q;
   assign zero  = zero_q;
   assign ovf   = ovf_q;
   assign lt    = lt_q;
   assign ltu   = ltu_q;

endmodule

// File: tb/tb_addsub_seq32.sv
// Self-checking bench for addsub_seq32: word-level reference model plus
// directed literal cases and randomized traffic.
module tb_addsub_seq32;

   localparam int unsigned BYTES = 4;
   localparam int          W     = 8 * BYTES;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready, busy, done;
   logic [W-1:0] q;
   logic         cout, zero, ovf, lt, ltu;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   addsub_seq32 #(.BYTES(BYTES)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .cout  (cout),
      .zero  (zero),
      .ovf   (ovf),
      .lt    (lt),
      .ltu   (ltu)
   );

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // ---------------- word-level reference model ----------------
   int           m_cnt  = 0;     // RUN cycles remaining; 0 means ready
   logic         m_done = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic         m_sub = 1'b0;
   logic [W-1:0] e_q = '0;
   logic         e_c = 1'b0, e_z = 1'b0, e_o = 1'b0, e_lt = 1'b0, e_ltu = 1'b0;

   task automatic model_eval();
      longint       sa, sb, r, lim;
      logic [W:0]   u;
      sa  = longint'($signed(m_a));
      sb  = longint'($signed(m_b));
      lim = 64'sd1 <<< (W - 1);
      r   = m_sub ? (sa - sb) : (sa + sb);
      u   = {1'b0, m_a} + {1'b0, m_b};
      e_q   = r[W-1:0];
      e_c   = m_sub ? (m_a >= m_b) : u[W];
      e_z   = (e_q == '0);
      e_o   = (r > lim - 1) || (r < -lim);
      e_lt  = m_sub && (sa < sb);
      e_ltu = m_sub && (m_a < m_b);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_done = 1'b0;
         e_q = '0; e_c = 1'b0; e_z = 1'b0; e_o = 1'b0; e_lt = 1'b0; e_ltu = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               m_a = a; m_b = b; m_sub = sub; m_cnt = BYTES;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               model_eval();
               m_done = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!reset) begin
         check("ctl ready/busy/done", {61'd0, ready, busy, done},
               {61'd0, (m_cnt == 0), (m_cnt != 0), m_done});
         check("result q/cout/zero/ovf/lt/ltu", {27'd0, q, cout, zero, ovf, lt, ltu},
               {27'd0, e_q, e_c, e_z, e_o, e_lt, e_ltu});
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   // flags order: {cout, zero, ovf, lt, ltu}
   task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic [W-1:0] xq, input logic [4:0] xf,
                        input bit mid);
      int k;
      a = ta; b = tb_v; sub = ts; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (mid && k == 1) begin
            a = ~ta; b = 32'h0001_2345; sub = ~ts; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      check({nm, " latency"}, 64'(k), 64'd4);
      check({nm, " dut"},   {27'd0, q, cout, zero, ovf, lt, ltu}, {27'd0, xq, xf});
      check({nm, " model"}, {27'd0, e_q, e_c, e_z, e_o, e_lt, e_ltu}, {27'd0, xq, xf});
      @(posedge clk); #1;
      check({nm, " done width"}, {63'd0, done}, 64'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'(1);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k1, k2, seen;
      #2;
      check("reset outputs", {52'd0, q, cout, zero, ovf, lt, ltu, done, busy, ready},
            {52'd0, 32'd0, 5'd0, 3'b001});
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      do_op("add ff+1",      32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 5'b00000, 1'b0);
      do_op("sub 5-5",       32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 5'b11000, 1'b0);
      do_op("sub 1-2",       32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 5'b00011, 1'b0);
      do_op("add 7fff+1",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 5'b00100, 1'b0);
      do_op("add ffff+1",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 5'b11000, 1'b0);
      do_op("sub 8000-1",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 5'b10110, 1'b0);
      do_op("mid-run start", 32'h0000_000A, 32'h0000_0014, 1'b0, 32'h0000_001E, 5'b00000, 1'b1);

      // back-to-back: start held in the DONE cycle
      a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(k1);
      check("b2b first latency", 64'(k1), 64'd4);
      check("b2b first q", {32'd0, q}, {32'd0, 32'h2345_6789});
      a = 32'h0000_0100; b = 32'h0000_0001; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k2 = 1;
      while (!done && k2 < 20) begin
         @(posedge clk); #1;
         k2++;
      end
      check("b2b done spacing", 64'(k2), 64'd5);
      check("b2b second", {27'd0, q, cout, zero, ovf, lt, ltu}, {27'd0, 32'h0000_00FF, 5'b10000});
      @(posedge clk); #1;

      // reset in the second RUN clock
      a = 32'h11; b = 32'h22; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      #1 reset = 1'b1;
      #1;
      check("async reset outputs", {52'd0, q, cout, zero, ovf, lt, ltu, done, busy, ready},
            {52'd0, 32'd0, 5'd0, 3'b001});
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      check("no done after reset", 64'(seen), 64'd0);
      do_op("add 3+4", 32'd3, 32'd4, 1'b0, 32'd7, 5'b00000, 1'b0);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) != 0);
         sub   = $urandom_range(0, 1) == 1;
         a     = pick();
         b     = pick();
         reset = ($urandom_range(0, 499) == 0);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
